weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 75 +++++++
 tb/tb_weight_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// weight_loader: streams upstream weight bytes into the neuron weight memory, one write per handshake.
module weight_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_weights,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] weight_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   loaded_count
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t          state;
  logic [ADDR_W:0] num;
  logic            hs;
  logic            legal;
  assign in_ready = state == LOAD && loaded_count < num;
  assign busy     = state == LOAD || state == FLUSH;
  // abort beats a coincident handshake, so the byte on that edge is dropped
  assign hs       = in_valid && in_ready && !abort;
  assign legal    = num_weights != '0 && num_weights <= (ADDR_W+1)'(DEPTH);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      num          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      weight_out   <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      loaded_count <= '0;
    end else begin
      wr_en <= hs;
      done  <= state == FLUSH;
      if (hs) begin
        wr_addr      <= loaded_count[ADDR_W-1:0];
        weight_out   <= in_data;
        loaded_count <= loaded_count + 1'b1;
      end
      case (state)
        IDLE:
          if (start) begin
            if (legal) begin
              state        <= LOAD;
              num          <= num_weights;
              loaded_count <= '0;
              err          <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        LOAD:
          if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (hs && loaded_count + 1'b1 == num) begin
            state <= FLUSH;
          end
        FLUSH:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: randomized sessions checked cycle by cycle against a session-level reference model.
module tb_weight_loader;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam int P_IDLE = 0, P_LOAD = 1, P_FLUSH = 2, P_DONE = 3;
  logic          clk = 0, reset = 0, start = 0, abort = 0, in_valid = 0;
  logic [AW:0]   num_weights = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] weight_out;
  logic [AW:0]   loaded_count;
  weight_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_weights(num_weights), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .weight_out(weight_out), .busy(busy), .done(done), .err(err),
    .loaded_count(loaded_count)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int writes = 0, dones = 0;
  bit check_en = 0;
  logic [7:0] data [DEPTH];
  logic [7:0] dut_mem [DEPTH];
  int m_phase = P_IDLE, m_target = 0, m_count = 0, m_addr = 0;
  bit m_err = 0, m_wr = 0;
  logic [7:0] m_data = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // session-level reference: a session accepts bytes while short of its target, each written a cycle later
  always @(posedge clk) begin
    m_wr = 0;
    if (!reset) begin
      m_phase = P_IDLE; m_target = 0; m_count = 0; m_err = 0; m_addr = 0; m_data = '0;
    end else if (m_phase == P_IDLE) begin
      if (start) begin
        if (int'(num_weights) >= 1 && int'(num_weights) <= DEPTH) begin
          m_phase = P_LOAD; m_target = int'(num_weights); m_count = 0; m_err = 0;
        end else m_err = 1;
      end
    end else if (m_phase == P_LOAD) begin
      if (abort) begin
        m_err = 1; m_phase = P_IDLE;
      end else if (in_valid && m_count < m_target) begin
        m_wr = 1; m_addr = m_count; m_data = in_data; m_count++;
        if (m_count == m_target) m_phase = P_FLUSH;
      end
    end else if (m_phase == P_FLUSH) m_phase = P_DONE;
    else m_phase = P_IDLE;
  end
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", in_ready, m_phase == P_LOAD && m_count < m_target);
      chk("busy", busy, m_phase == P_LOAD || m_phase == P_FLUSH);
      chk("done", done, m_phase == P_DONE);
      chk("err", err, m_err);
      chk("loaded_count", loaded_count, m_count);
      chk("wr_en", wr_en, m_wr);
      if (m_wr) begin
        chk("wr_addr", wr_addr, m_addr);
        chk("weight_out", weight_out, m_data);
      end
      if (wr_en === 1'b1) begin
        dut_mem[wr_addr] = weight_out;
        writes++;
      end
      if (done === 1'b1) dones++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic settle();
    repeat (4) tick();
  endtask
  task automatic prep();
    for (int i = 0; i < DEPTH; i++) begin
      data[i] = 8'($urandom);
      dut_mem[i] = ~data[i];
    end
    writes = 0;
    dones = 0;
  endtask
  task automatic begin_session(input int n);
    tick();
    start = 1;
    num_weights = (AW+1)'(n);
    tick();
    start = 0;
  endtask
  task automatic feed(input int lo, input int hi, input int gap);
    int i = lo;
    int guard = 0;
    while (i < hi && guard < 4000) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data = data[i];
      if (in_valid && in_ready) i++;
      tick();
      guard++;
    end
    in_valid = 0;
    chk("feed_progress", i, hi);
  endtask
  task automatic mem_check(input string name, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (dut_mem[i] !== data[i]) bad++;
    chk(name, bad, 0);
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_weight_out"}, weight_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_loaded_count"}, loaded_count, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    check_reset_values("reset");
    check_en = 1;
    reset = 1;
    prep();
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
    begin_session(4);
    feed(0, 4, 0);
    settle();
    chk("four_writes", writes, 4);
    chk("four_done", dones, 1);
    chk("four_count", loaded_count, 4);
    chk("four_err", err, 0);
    mem_check("four_mem", 4);
    prep();
    begin_session(256);
    feed(0, 256, 30);
    settle();
    chk("full_writes", writes, 256);
    chk("full_done", dones, 1);
    chk("full_count", loaded_count, 256);
    mem_check("full_mem", 256);
    prep();
    begin_session(0);
    chk("zero_err", err, 1);
    chk("zero_busy", busy, 0);
    begin_session(257);
    chk("big_err", err, 1);
    chk("big_busy", busy, 0);
    chk("illegal_writes", writes, 0);
    begin_session(2);
    chk("legal_clears_err", err, 0);
    feed(0, 2, 0);
    settle();
    chk("two_writes", writes, 2);
    mem_check("two_mem", 2);
    prep();
    begin_session(8);
    feed(0, 3, 0);
    abort = 1;
    in_valid = 1;
    in_data = data[3];
    tick();
    abort = 0;
    in_valid = 0;
    settle();
    chk("abort_writes", writes, 3);
    chk("abort_count", loaded_count, 3);
    chk("abort_err", err, 1);
    chk("abort_done", dones, 0);
    chk("abort_idle", busy, 0);
    mem_check("abort_mem", 3);
    prep();
    begin_session(10);
    feed(0, 5, 20);
    reset = 0;
    in_valid = 1;
    in_data = data[5];
    tick();
    check_reset_values("midreset");
    reset = 1;
    in_valid = 0;
    settle();
    chk("midreset_writes", writes, 5);
    chk("midreset_done", dones, 0);
    prep();
    begin_session(6);
    feed(0, 6, 25);
    settle();
    chk("after_reset_writes", writes, 6);
    mem_check("after_reset_mem", 6);
    prep();
    begin_session(5);
    feed(0, 2, 0);
    start = 1;
    num_weights = 9'd3;
    tick();
    start = 0;
    feed(2, 5, 0);
    tick();
    start = 1;
    num_weights = 9'd3;
    tick();
    start = 0;
    settle();
    chk("ignore_start_writes", writes, 5);
    chk("ignore_start_done", dones, 1);
    chk("ignore_start_count", loaded_count, 5);
    chk("ignore_start_busy", busy, 0);
    mem_check("ignore_start_mem", 5);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 20);
      prep();
      begin_session(n);
      feed(0, n, 40);
      settle();
      chk("rand_writes", writes, n);
      chk("rand_done", dones, 1);
      mem_check("rand_mem", n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
